// File: rtl/div_pkg.sv
// Shared constants for the sequential unsigned divider.
// Latency: none (package only).
// Backpressure: none (package only).
package div_pkg;

  // Default operand / quotient / remainder width.
  localparam int DEF_WIDTH = 4;

  // Sequencer state encoding.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  // Quotient reported for a zero divisor is all ones at whatever width the
  // divider is built with; callers size it with this helper.
  function automatic logic [63:0] dbz_quot_all_ones();
    return '1;
  endfunction

endpackage : div_pkg

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract divisor.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle by the owning sequencer.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  // The shifted partial remainder needs one extra bit: it can exceed the
  // divisor range before the subtraction brings it back under the divisor.
  logic [WIDTH:0]   shifted;
  // One more bit again so the borrow out of the subtraction is explicit.
  logic [WIDTH+1:0] trial;
  // After a successful subtract the result is below the divisor, so the top
  // magnitude bit of the trial is always zero and is not needed downstream.
  logic             unused_trial_msb;

  assign shifted          = {rem_i, bit_i};
  assign trial            = {1'b0, shifted} - {2'b00, divisor_i};
  assign unused_trial_msb = trial[WIDTH];

  // Non-negative trial (no borrow) means the divisor fits: take the
  // difference and emit a one; otherwise restore the shifted remainder.
  always_comb begin
    q_o   = ~trial[WIDTH+1];
    rem_o = shifted[WIDTH-1:0];
    if (q_o) begin
      rem_o = trial[WIDTH-1:0];
    end
  end

endmodule : div_step

// File: rtl/div_seq_ctrl.sv
// Sequential unsigned divider: one restoring step per clock, WIDTH steps per op.
// Latency: start accepted on edge N, done pulses in the cycle after edge N+WIDTH; zero divisor finishes in 1 cycle.
// Backpressure: busy is high during CALC; start is ignored while busy, accepted in IDLE or DONE.
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rem,
  output logic             div_by_zero
);

  localparam int               CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  // Zero-divisor quotient, sized from the package's all-ones helper.
  logic [63:0]      dbz_wide;
  logic [WIDTH-1:0] dbz_quot;
  logic [63:WIDTH]  unused_dbz_hi;

  assign dbz_wide      = dbz_quot_all_ones();
  assign dbz_quot      = dbz_wide[WIDTH-1:0];
  assign unused_dbz_hi = dbz_wide[63:WIDTH];

  div_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  // Dividend shift register: dividend bits leave at the top while quotient
  // bits enter at the bottom, so after WIDTH steps it holds the quotient.
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] prem_q;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] rem_q;
  logic             dbz_q;
  logic             busy_q;
  logic             done_q;

  // Combinational step results for the current CALC cycle.
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] quot_next;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i    (prem_q),
    .bit_i    (dvd_q[WIDTH-1]),
    .divisor_i(dvs_q),
    .rem_o    (step_rem),
    .q_o      (step_q)
  );

  assign quot_next = {dvd_q[WIDTH-2:0], step_q};

  // Sequencer: operand capture, per-cycle restoring step, result load and
  // the registered busy/done flags, all moving together with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      out_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (in2 == '0) begin
              // Zero divisor short-circuits straight to a result.
              out_q   <= dbz_quot;
              rem_q   <= in1;
              dbz_q   <= 1'b1;
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              dvd_q   <= in1;
              dvs_q   <= in2;
              prem_q  <= '0;
              cnt_q   <= '0;
              state_q <= S_CALC;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end

        S_CALC: begin
          // start and operand inputs are deliberately not looked at here.
          prem_q <= step_rem;
          dvd_q  <= quot_next;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            out_q   <= quot_next;
            rem_q   <= step_rem;
            dbz_q   <= 1'b0;
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end

        default: begin
          // Unreachable encoding: recover to IDLE without touching results.
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign out         = out_q;
  assign rem         = rem_q;
  assign div_by_zero = dbz_q;

endmodule : div_seq_ctrl

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed scenarios plus random traffic.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_div_seq_ctrl;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         busy;
  logic         done;
  logic [W-1:0] out;
  logic [W-1:0] rem;
  logic         div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  div_seq_ctrl #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in1        (in1),
    .in2        (in2),
    .busy       (busy),
    .done       (done),
    .out        (out),
    .rem        (rem),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: an operation is "cycles left" plus a precomputed
  // quotient/remainder from plain integer arithmetic.
  int           m_left;
  bit           m_done;
  bit           m_dbz;
  logic [W-1:0] m_out;
  logic [W-1:0] m_rem;
  logic [W-1:0] p_q;
  logic [W-1:0] p_r;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0;
      m_done = 0;
      m_dbz  = 0;
      m_out  = '0;
      m_rem  = '0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      m_done = (m_left == 0);
      if (m_left == 0) begin
        m_out = p_q;
        m_rem = p_r;
        m_dbz = 0;
      end
    end else if (start) begin
      if (in2 == 0) begin
        m_done = 1;
        m_dbz  = 1;
        m_out  = (1 << W) - 1;
        m_rem  = in1;
      end else begin
        m_done = 0;
        m_left = W;
        p_q    = in1 / in2;
        p_r    = in1 % in2;
      end
    end else begin
      m_done = 0;
    end
  end

  // Every cycle, away from the rising edge, the DUT must match the model.
  always @(negedge clk) begin
    check("busy", busy, (m_left > 0) ? 1 : 0);
    check("done", done, m_done);
    check("out", out, m_out);
    check("rem", rem, m_rem);
    check("div_by_zero", div_by_zero, m_dbz);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Issue one op, optionally re-pulse start at step 'glitch' (0 = never),
  // scramble operand inputs while waiting, and check literal expectations.
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                    input int eq, input int er, input int edbz,
                    input int elat, input int glitch, input string tag);
    int k;
    int nb;
    bit seen;
    in1   = a;
    in2   = b;
    start = 1'b1;
    tick();
    k    = 1;
    nb   = 0;
    seen = 0;
    while (k <= 20 && !seen) begin
      if (busy) nb++;
      if (done) begin
        seen = 1;
      end else begin
        if (k == glitch) begin
          start = 1'b1;
          in1   = 4'd9;
          in2   = 4'd2;
        end else begin
          start = 1'b0;
          in1   = W'($urandom);
          in2   = W'($urandom);
        end
        tick();
        k++;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, seen ? k : -1, elat);
    check({tag, "_busy_cycles"}, nb, elat - 1);
    check({tag, "_out"}, out, eq);
    check({tag, "_rem"}, rem, er);
    check({tag, "_dbz"}, div_by_zero, edbz);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    in1   = '0;
    in2   = '0;
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_out", out, 0);
    check("reset_rem", rem, 0);
    check("reset_dbz", div_by_zero, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    op(4'd13, 4'd3, 4, 1, 0, W + 1, 0, "div13_3");
    tick();
    check("done_one_cycle", done, 0);
    op(4'd7, 4'd0, 15, 7, 1, 1, 0, "dbz7");
    tick();
    op(4'd15, 4'd1, 15, 0, 0, W + 1, 0, "div15_1");
    tick();
    op(4'd3, 4'd5, 0, 3, 0, W + 1, 0, "div3_5");
    tick();
    op(4'd15, 4'd15, 1, 0, 0, W + 1, 0, "div15_15");
    tick();
    op(4'd0, 4'd9, 0, 0, 0, W + 1, 0, "div0_9");
    tick();
    op(4'd12, 4'd4, 3, 0, 0, W + 1, 2, "busy_start");
    tick();

    // Back-to-back: second start issued in the first op's DONE cycle.
    op(4'd13, 4'd3, 4, 1, 0, W + 1, 0, "b2b_first");
    op(4'd14, 4'd4, 3, 2, 0, W + 1, 0, "b2b_second");
    tick();

    // Reset during the second CALC cycle.
    in1   = 4'd13;
    in2   = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #1 rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_out", out, 0);
    check("midrst_rem", rem, 0);
    check("midrst_dbz", div_by_zero, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("midrst_no_done", done, 0);
    end
    op(4'd13, 4'd3, 4, 1, 0, W + 1, 0, "after_rst");
    tick();

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 2) == 0);
      in1   = W'($urandom);
      in2   = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      if ($urandom_range(0, 149) == 0) rst = 1'b1;
      tick();
      rst = 1'b0;
    end
    start = 1'b0;
    repeat (W + 3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_div_seq_ctrl
